// File: rtl/sram_frame_pkg.sv
// Purpose : shared constants and FSM encoding for the SRAM frame read path.
// Latency : n/a (package only).
// Backpr. : n/a (package only).
// Contents: SRAM bus widths shared with the controller and display stage,
//           default frame geometry and read latency, fetch FSM state type.
package sram_frame_pkg;

  // Bus widths shared with the SRAM controller and the display stage.
  localparam int SRAM_ADDR_W = 19;
  localparam int SRAM_DATA_W = 16;

  // Default frame geometry: 320x240 at 1bpp packed into 16-bit words.
  localparam int DEF_FRAME_WORDS = 4800;
  localparam int DEF_MAX_FRAMES  = 109;
  localparam int DEF_IDX_W       = 10;

  // Output buffering and controller read latency.
  localparam int DEF_FIFO_DEPTH  = 8;
  localparam int DEF_RD_LAT      = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/frame_fifo.sv
// Purpose : synchronous FIFO with first-word fall-through on rdata.
// Latency : a pushed word is visible on rdata the cycle after the push.
// Backpr. : push while full is dropped unless a pop happens the same cycle;
//           pop while empty is ignored.
// Ports   : clk, rst (sync, active-high), push/wdata, pop/rdata,
//           count (occupancy), empty, full.
module frame_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop frees the head slot in the same cycle, so push-at-full is fine then.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/sram_frame_fetch.sv
// Purpose : on start, stream one stored frame out of SRAM in address order
//           into a small FIFO that feeds the display line logic.
// Latency : first pix_valid RD_LAT+1 cycles after the edge that takes start;
//           one word per cycle after that while pix_ready is high.
// Backpr. : reads are only issued against free FIFO slots (credit), so a
//           stalled consumer stops SRAM reads without losing words.
// Ports   : clk, rst (sync, active-high); start/frame_idx request;
//           busy/done/err status; sram_selec/read/write/addr/rdata to the
//           SRAM controller; pix_data/pix_valid/pix_ready to the consumer.
module sram_frame_fetch
  import sram_frame_pkg::*;
#(
  parameter int ADDR_W      = SRAM_ADDR_W,
  parameter int DATA_W      = SRAM_DATA_W,
  parameter int FRAME_WORDS = DEF_FRAME_WORDS,
  parameter int MAX_FRAMES  = DEF_MAX_FRAMES,
  parameter int IDX_W       = DEF_IDX_W,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int RD_LAT      = DEF_RD_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [IDX_W-1:0]  frame_idx,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              sram_selec,
  output logic              sram_read,
  output logic              sram_write,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  input  logic              pix_ready
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int INF_W = $clog2(RD_LAT + 1);
  localparam int OCC_W = CNT_W + INF_W;
  localparam int WC_W  = $clog2(FRAME_WORDS + 1);

  fetch_state_t      state;
  fetch_state_t      state_nxt;

  logic [ADDR_W-1:0] base;
  logic [WC_W-1:0]   word_cnt;
  logic [RD_LAT-1:0] issued_sr;
  logic [INF_W-1:0]  inflight;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic              fifo_full;
  logic              push_c;
  logic [OCC_W-1:0]  occupied;
  logic              has_credit;
  logic              idx_ok;

  logic              accept_c;
  logic              reject_c;
  logic              issue_c;
  logic              last_issue_c;
  logic              drain_done_c;

  assign idx_ok     = (frame_idx < IDX_W'(MAX_FRAMES));
  // A flag leaving the top of the shift register marks the cycle the
  // controller's read data for that issue is valid.
  assign push_c     = issued_sr[RD_LAT-1];
  assign sram_selec = busy;
  assign sram_write = 1'b0;
  assign pix_valid  = !fifo_empty;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + INF_W'(issued_sr[i]);
    end
  end

  // Every issued read owns a FIFO slot until popped: either still in flight
  // or already stored. Credit exists while that total is below the depth.
  assign occupied   = OCC_W'(fifo_count) + OCC_W'(inflight);
  assign has_credit = (occupied < OCC_W'(FIFO_DEPTH));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept_c)     state_nxt = FETCH;
      FETCH:   if (last_issue_c) state_nxt = DRAIN;
      DRAIN:   if (drain_done_c) state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  // Per-state control decisions.
  always_comb begin
    accept_c     = 1'b0;
    reject_c     = 1'b0;
    issue_c      = 1'b0;
    last_issue_c = 1'b0;
    drain_done_c = 1'b0;
    case (state)
      IDLE: begin
        accept_c = start && idx_ok;
        reject_c = start && !idx_ok;
      end
      FETCH: begin
        issue_c      = has_credit;
        last_issue_c = has_credit && (word_cnt == WC_W'(FRAME_WORDS - 1));
      end
      DRAIN: begin
        // No read in flight means no push can land this cycle either.
        drain_done_c = (inflight == '0) && fifo_empty;
      end
      default: ;
    endcase
  end

  // Registered outputs and datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      sram_read <= 1'b0;
      sram_addr <= '0;
      base      <= '0;
      word_cnt  <= '0;
      issued_sr <= '0;
    end else begin
      done      <= reject_c || drain_done_c;
      sram_read <= issue_c;
      issued_sr <= (issued_sr << 1) | RD_LAT'(issue_c);
      if (accept_c) begin
        base     <= ADDR_W'(frame_idx) * ADDR_W'(FRAME_WORDS);
        word_cnt <= '0;
        err      <= 1'b0;
        busy     <= 1'b1;
      end
      if (reject_c) err <= 1'b1;
      if (issue_c) begin
        sram_addr <= base + ADDR_W'(word_cnt);
        word_cnt  <= word_cnt + 1'b1;
      end
      if (drain_done_c) busy <= 1'b0;
    end
  end

  frame_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_c),
    .pop   (pix_ready),
    .wdata (sram_rdata),
    .rdata (pix_data),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // The credit scheme must never let a word arrive at a full FIFO unpopped.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push_c && fifo_full && !pix_ready));

endmodule

// File: tb/tb_sram_frame_fetch.sv
// Purpose : self-checking bench for sram_frame_fetch against an SRAM model
//           that returns addr[15:0] and a frame model built from base+i.
// Latency : SRAM model returns data RD_LAT edges after the issuing edge.
// Backpr. : pix_ready is held, stalled, or randomised per scenario.
module tb_sram_frame_fetch;

  localparam int FW     = 4800;
  localparam int MAXF   = 109;
  localparam int DEPTH  = 8;
  localparam int RD_LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  frame_idx = '0;
  logic        busy, done, err, sram_selec, sram_read, sram_write;
  logic [18:0] sram_addr;
  logic [15:0] sram_rdata;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        pix_ready = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  sram_frame_fetch dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .frame_idx  (frame_idx),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .sram_selec (sram_selec),
    .sram_read  (sram_read),
    .sram_write (sram_write),
    .sram_addr  (sram_addr),
    .sram_rdata (sram_rdata),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready)
  );

  always #5 clk = ~clk;

  // SRAM controller model: the word at address A holds A[15:0]; data for a
  // read seen at one edge is presented until the edge RD_LAT-1 later.
  logic        pv [RD_LAT-1];
  logic [15:0] pd [RD_LAT-1];
  logic [15:0] junk;
  always @(posedge clk) begin
    pv[0] <= sram_read;
    pd[0] <= sram_addr[15:0];
    for (int i = 1; i < RD_LAT - 1; i++) begin
      pv[i] <= pv[i-1];
      pd[i] <= pd[i-1];
    end
    junk <= 16'($urandom);
  end
  assign sram_rdata = pv[RD_LAT-2] ? pd[RD_LAT-2] : junk;

  // Observation log (written only here).
  int          cyc = 0;
  logic [18:0] addr_log [$];
  logic [15:0] pop_log [$];
  int          done_cnt = 0, done_cyc_last = 0, pop_cyc_last = 0;
  int          rd_out = 0, max_out = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) rd_out = 0;
    else begin
      if (sram_read) begin addr_log.push_back(sram_addr); rd_out++; end
      if (pix_valid && pix_ready) begin
        pop_log.push_back(pix_data); pop_cyc_last = cyc; rd_out--;
      end
      if (done) begin done_cnt++; done_cyc_last = cyc; end
      if (rd_out > max_out) max_out = rd_out;
    end
  end

  task automatic pulse_start(input int idx);
    @(posedge clk); #1; start = 1'b1; frame_idx = idx[9:0];
    @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget, output bit to);
    int n = 0;
    while (done_cnt == d0 && n < budget) begin @(negedge clk); n++; end
    to = (done_cnt == d0);
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; pix_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++; if (busy !== 1'b0)       begin miscompares++; $display("FAIL reset busy: got %b want 0", busy); end
    vectors++; if (done !== 1'b0)       begin miscompares++; $display("FAIL reset done: got %b want 0", done); end
    vectors++; if (err !== 1'b0)        begin miscompares++; $display("FAIL reset err: got %b want 0", err); end
    vectors++; if (sram_selec !== 1'b0) begin miscompares++; $display("FAIL reset selec: got %b want 0", sram_selec); end
    vectors++; if (sram_read !== 1'b0)  begin miscompares++; $display("FAIL reset read: got %b want 0", sram_read); end
    vectors++; if (sram_write !== 1'b0) begin miscompares++; $display("FAIL reset write: got %b want 0", sram_write); end
    vectors++; if (sram_addr !== 19'd0) begin miscompares++; $display("FAIL reset addr: got %0d want 0", sram_addr); end
    vectors++; if (pix_valid !== 1'b0)  begin miscompares++; $display("FAIL reset pix_valid: got %b want 0", pix_valid); end
    @(posedge clk); #1; rst = 1'b0;
  endtask

  task automatic test_frame0;
    int a0 = addr_log.size(), p0 = pop_log.size(), d0 = done_cnt, lat;
    bit to;
    pix_ready = 1'b1;
    pulse_start(0);
    for (lat = 0; lat < 20; lat++) begin
      @(negedge clk);
      if (pix_valid) break;
    end
    vectors++; if (lat !== RD_LAT + 1) begin miscompares++; $display("FAIL f0 latency: got %0d want %0d", lat, RD_LAT + 1); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL f0 busy: got %b want 1", busy); end
    wait_done(d0, 6000, to);
    vectors++; if (to) begin miscompares++; $display("FAIL f0 timeout: no done within budget"); end
    vectors++; if (addr_log.size() - a0 != FW) begin miscompares++; $display("FAIL f0 reads: got %0d want %0d", addr_log.size() - a0, FW); end
    vectors++; if (pop_log.size() - p0 != FW) begin miscompares++; $display("FAIL f0 pops: got %0d want %0d", pop_log.size() - p0, FW); end
    for (int i = 0; i < FW && a0 + i < addr_log.size(); i++) begin
      vectors++; if (addr_log[a0+i] !== 19'(i)) begin miscompares++; $display("FAIL f0 addr[%0d]: got %0d want %0d", i, addr_log[a0+i], i); end
    end
    for (int i = 0; i < FW && p0 + i < pop_log.size(); i++) begin
      vectors++; if (pop_log[p0+i] !== 16'(i)) begin miscompares++; $display("FAIL f0 data[%0d]: got %h want %h", i, pop_log[p0+i], 16'(i)); end
    end
    vectors++; if (done_cnt - d0 != 1) begin miscompares++; $display("FAIL f0 done count: got %0d want 1", done_cnt - d0); end
    vectors++; if (done_cyc_last <= pop_cyc_last) begin miscompares++; $display("FAIL f0 done order: done cyc %0d, last pop cyc %0d", done_cyc_last, pop_cyc_last); end
    vectors++; if (err !== 1'b0 || busy !== 1'b0 || sram_selec !== 1'b0) begin miscompares++; $display("FAIL f0 end status: err %b busy %b selec %b want 000", err, busy, sram_selec); end
  endtask

  task automatic test_backpressure;
    int a0 = addr_log.size(), p0 = pop_log.size(), d0 = done_cnt, base = 3 * FW;
    bit to;
    pix_ready = 1'b0;
    pulse_start(3);
    repeat (50) @(negedge clk);
    vectors++; if (addr_log.size() - a0 != DEPTH) begin miscompares++; $display("FAIL bp stalled reads: got %0d want %0d", addr_log.size() - a0, DEPTH); end
    for (int i = 0; i < DEPTH && a0 + i < addr_log.size(); i++) begin
      vectors++; if (addr_log[a0+i] !== 19'(base + i)) begin miscompares++; $display("FAIL bp addr[%0d]: got %0d want %0d", i, addr_log[a0+i], base + i); end
    end
    vectors++; if (sram_read !== 1'b0) begin miscompares++; $display("FAIL bp read while stalled: got %b want 0", sram_read); end
    vectors++; if (pix_valid !== 1'b1) begin miscompares++; $display("FAIL bp pix_valid: got %b want 1", pix_valid); end
    vectors++; if (max_out != DEPTH) begin miscompares++; $display("FAIL bp outstanding: got %0d want %0d", max_out, DEPTH); end
    @(posedge clk); #1; pix_ready = 1'b1;
    wait_done(d0, 6000, to);
    vectors++; if (to) begin miscompares++; $display("FAIL bp timeout: no done within budget"); end
    vectors++; if (addr_log.size() - a0 != FW) begin miscompares++; $display("FAIL bp reads: got %0d want %0d", addr_log.size() - a0, FW); end
    for (int i = 0; i < FW && a0 + i < addr_log.size(); i++) begin
      vectors++; if (addr_log[a0+i] !== 19'(base + i)) begin miscompares++; $display("FAIL bp addr[%0d]: got %0d want %0d", i, addr_log[a0+i], base + i); end
    end
    vectors++; if (pop_log.size() - p0 != FW) begin miscompares++; $display("FAIL bp pops: got %0d want %0d", pop_log.size() - p0, FW); end
    for (int i = 0; i < FW && p0 + i < pop_log.size(); i++) begin
      vectors++; if (pop_log[p0+i] !== 16'(base + i)) begin miscompares++; $display("FAIL bp data[%0d]: got %h want %h", i, pop_log[p0+i], 16'(base + i)); end
    end
    vectors++; if (done_cnt - d0 != 1) begin miscompares++; $display("FAIL bp done count: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_random_last;
    int a0 = addr_log.size(), p0 = pop_log.size(), d0 = done_cnt, base = 108 * FW, n = 0;
    pix_ready = 1'b1;
    pulse_start(108);
    while (done_cnt == d0 && n < 30000) begin
      @(posedge clk); #1; pix_ready = ($urandom_range(0, 3) != 0); n++;
    end
    pix_ready = 1'b1;
    repeat (6) @(negedge clk);
    vectors++; if (done_cnt == d0) begin miscompares++; $display("FAIL rnd timeout: no done within budget"); end
    vectors++; if (addr_log.size() - a0 != FW) begin miscompares++; $display("FAIL rnd reads: got %0d want %0d", addr_log.size() - a0, FW); end
    vectors++; if (addr_log.size() > a0 && addr_log[addr_log.size()-1] !== 19'd523199) begin miscompares++; $display("FAIL rnd last addr: got %0d want 523199", addr_log[addr_log.size()-1]); end
    for (int i = 0; i < FW && a0 + i < addr_log.size(); i++) begin
      vectors++; if (addr_log[a0+i] !== 19'(base + i)) begin miscompares++; $display("FAIL rnd addr[%0d]: got %0d want %0d", i, addr_log[a0+i], base + i); end
    end
    vectors++; if (pop_log.size() - p0 != FW) begin miscompares++; $display("FAIL rnd pops: got %0d want %0d", pop_log.size() - p0, FW); end
    for (int i = 0; i < FW && p0 + i < pop_log.size(); i++) begin
      vectors++; if (pop_log[p0+i] !== 16'(base + i)) begin miscompares++; $display("FAIL rnd data[%0d]: got %h want %h", i, pop_log[p0+i], 16'(base + i)); end
    end
    vectors++; if (max_out > DEPTH) begin miscompares++; $display("FAIL rnd outstanding: got %0d want <= %0d", max_out, DEPTH); end
    vectors++; if (done_cnt - d0 != 1) begin miscompares++; $display("FAIL rnd done count: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_bad_idx;
    int a0 = addr_log.size(), d0 = done_cnt;
    @(posedge clk); #1; start = 1'b1; frame_idx = 10'(MAXF);
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL bad done pulse: got %b want 1", done); end
    vectors++; if (err !== 1'b1)  begin miscompares++; $display("FAIL bad err: got %b want 1", err); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL bad busy: got %b want 0", busy); end
    @(negedge clk);
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL bad done width: got %b want 0", done); end
    repeat (5) @(negedge clk);
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL bad err sticky: got %b want 1", err); end
    vectors++; if (addr_log.size() != a0) begin miscompares++; $display("FAIL bad reads: got %0d want 0", addr_log.size() - a0); end
    vectors++; if (done_cnt - d0 != 1) begin miscompares++; $display("FAIL bad done count: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_double_start;
    int a0 = addr_log.size(), d0 = done_cnt, base = 5 * FW;
    bit to;
    pix_ready = 1'b1;
    pulse_start(5);
    @(negedge clk);
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL dbl err clear: got %b want 0", err); end
    repeat (100) @(negedge clk);
    pulse_start(7);
    wait_done(d0, 6000, to);
    vectors++; if (to) begin miscompares++; $display("FAIL dbl timeout: no done within budget"); end
    vectors++; if (addr_log.size() - a0 != FW) begin miscompares++; $display("FAIL dbl reads: got %0d want %0d", addr_log.size() - a0, FW); end
    for (int i = 0; i < FW && a0 + i < addr_log.size(); i++) begin
      vectors++; if (addr_log[a0+i] !== 19'(base + i)) begin miscompares++; $display("FAIL dbl addr[%0d]: got %0d want %0d", i, addr_log[a0+i], base + i); end
    end
    vectors++; if (done_cnt - d0 != 1) begin miscompares++; $display("FAIL dbl done count: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_reset_midframe;
    int a0 = addr_log.size(), d0 = done_cnt, n = 0, a1, p2, base = FW;
    bit to;
    pix_ready = 1'b1;
    pulse_start(2);
    while (addr_log.size() - a0 < 2000 && n < 5000) begin @(negedge clk); n++; end
    vectors++; if (addr_log.size() - a0 < 2000) begin miscompares++; $display("FAIL rstm reach 2000: got %0d reads", addr_log.size() - a0); end
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vectors++; if (busy !== 1'b0)       begin miscompares++; $display("FAIL rstm busy: got %b want 0", busy); end
    vectors++; if (done !== 1'b0)       begin miscompares++; $display("FAIL rstm done: got %b want 0", done); end
    vectors++; if (err !== 1'b0)        begin miscompares++; $display("FAIL rstm err: got %b want 0", err); end
    vectors++; if (sram_selec !== 1'b0) begin miscompares++; $display("FAIL rstm selec: got %b want 0", sram_selec); end
    vectors++; if (sram_read !== 1'b0)  begin miscompares++; $display("FAIL rstm read: got %b want 0", sram_read); end
    vectors++; if (sram_addr !== 19'd0) begin miscompares++; $display("FAIL rstm addr: got %0d want 0", sram_addr); end
    vectors++; if (pix_valid !== 1'b0)  begin miscompares++; $display("FAIL rstm pix_valid: got %b want 0", pix_valid); end
    @(posedge clk); #1; rst = 1'b0;
    a1 = addr_log.size();
    repeat (20) @(negedge clk);
    vectors++; if (done_cnt != d0) begin miscompares++; $display("FAIL rstm spurious done: got %0d want 0", done_cnt - d0); end
    vectors++; if (addr_log.size() != a1 || pix_valid !== 1'b0) begin miscompares++; $display("FAIL rstm idle: reads %0d pix_valid %b want 0 0", addr_log.size() - a1, pix_valid); end
    p2 = pop_log.size();
    pulse_start(1);
    wait_done(d0, 6000, to);
    vectors++; if (to) begin miscompares++; $display("FAIL rstm2 timeout: no done within budget"); end
    vectors++; if (addr_log.size() - a1 != FW) begin miscompares++; $display("FAIL rstm2 reads: got %0d want %0d", addr_log.size() - a1, FW); end
    for (int i = 0; i < FW && a1 + i < addr_log.size(); i++) begin
      vectors++; if (addr_log[a1+i] !== 19'(base + i)) begin miscompares++; $display("FAIL rstm2 addr[%0d]: got %0d want %0d", i, addr_log[a1+i], base + i); end
    end
    vectors++; if (pop_log.size() - p2 != FW) begin miscompares++; $display("FAIL rstm2 pops: got %0d want %0d", pop_log.size() - p2, FW); end
    for (int i = 0; i < FW && p2 + i < pop_log.size(); i++) begin
      vectors++; if (pop_log[p2+i] !== 16'(base + i)) begin miscompares++; $display("FAIL rstm2 data[%0d]: got %h want %h", i, pop_log[p2+i], 16'(base + i)); end
    end
    vectors++; if (done_cnt - d0 != 1) begin miscompares++; $display("FAIL rstm2 done count: got %0d want 1", done_cnt - d0); end
  endtask

  initial begin
    test_reset();
    test_frame0();
    test_backpressure();
    test_random_last();
    test_bad_idx();
    test_double_start();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
